// File: rtl/spram_bank_fifo_pkg.sv
// Shared types for the single-port-RAM bank FIFO: arbiter priority encoding
// and output-buffer depth.
package spram_bank_fifo_pkg;

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

    localparam int OB_DEPTH = 2;

endpackage

// File: rtl/sp_ram.sv
// Behavioural single-port RAM with a 1-cycle registered read; one access per
// cycle. Drop-in slot for a vendor macro.
module sp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/spram_bank_fifo.sv
// One bank of the ping-pong FIFO: single-port RAM shared between writes and
// prefetch reads, with a 2-entry registered output buffer in front.
module spram_bank_fifo
    import spram_bank_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam logic [CNT_WIDTH-1:0] RAM_FULL = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0]              wp, rp;
    logic [CNT_WIDTH-1:0]               ram_cnt;
    logic                               rd_inflight;
    prio_e                              prio;
    logic [1:0][DATA_WIDTH-1:0]         ob;
    logic [1:0]                         ob_cnt;
    logic [1:0]                         ob_cnt_np;
    logic [DATA_WIDTH-1:0]              ram_rdata;

    logic pop, ram_full, rd_req, wr_req, grant_rd, grant_wr;

    assign pop       = (ob_cnt != 2'd0) && out_ready;
    assign ob_cnt_np = ob_cnt - {1'b0, pop};
    assign ram_full  = (ram_cnt == RAM_FULL);

    // A read is only issued when its data is guaranteed a slot in the buffer,
    // counting the word already in flight and this cycle's pop.
    assign rd_req   = (ram_cnt != '0) &&
                      ((ob_cnt_np + {1'b0, rd_inflight}) < 2'(OB_DEPTH));
    assign wr_req   = in_valid && !ram_full;
    assign grant_rd = rd_req && (!wr_req || prio == PRIO_RD);
    assign grant_wr = wr_req && !grant_rd;

    // Independent of in_valid: a favoured pending read blocks the write port.
    assign in_ready  = !ram_full && !(rd_req && prio == PRIO_RD);
    assign out_valid = (ob_cnt != 2'd0);
    assign out_data  = ob[0];

    sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (grant_rd | grant_wr),
        .we    (grant_wr),
        .addr  (grant_wr ? wp : rp),
        .wdata (in_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp          <= '0;
            rp          <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            prio        <= PRIO_WR;
            ob          <= '0;
            ob_cnt      <= 2'd0;
            count       <= '0;
        end else begin
            if (grant_wr) wp <= wp + ADDR_WIDTH'(1);
            if (grant_rd) rp <= rp + ADDR_WIDTH'(1);
            ram_cnt     <= ram_cnt + CNT_WIDTH'(grant_wr) - CNT_WIDTH'(grant_rd);
            rd_inflight <= grant_rd;
            count       <= count + CNT_WIDTH'(grant_wr) - CNT_WIDTH'(pop);

            if (rd_req && wr_req)
                prio <= grant_rd ? PRIO_WR : PRIO_RD;

            // Returning RAM data lands behind whatever survives this cycle's pop.
            case ({rd_inflight, pop})
                2'b01: begin
                    ob[0]  <= ob[1];
                    ob_cnt <= ob_cnt - 2'd1;
                end
                2'b10: begin
                    if (ob_cnt == 2'd0) ob[0] <= ram_rdata;
                    else                ob[1] <= ram_rdata;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob[0] <= ram_rdata;
                    end else begin
                        ob[0] <= ob[1];
                        ob[1] <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
